// File: rtl/cpu_pkg.sv
// Shared constants and types for the 9-bit RISC core.
// Holds fetch widths, the halt word, the fetch FSM type and opcodes.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;

  // ROM fill value; fetching it ends the program.
  localparam logic [INST_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LSH = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_LDM = 3'b101;
  localparam logic [2:0] OP_STR = 3'b110;
  localparam logic [2:0] OP_BNE = 3'b111;

  function automatic logic [2:0] opcode_of(
    input logic [INST_W-1:0] inst
  );
    return inst[INST_W-1 -: 3];
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, ROM address, one-entry fetch
// buffer with valid/ready to decode, redirect, halt and issue count.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, start_addr begin fetching (IDLE/HALT only)
//   imem_pc/imem_inst ROM address out, combinational ROM data in
//   inst_valid/ready  fetch buffer handshake to decode
//   inst_out/inst_pc  buffered instruction and its address
//   redirect(_pc)     taken-branch target from execute
//   busy, done        RUN state / HALT with empty buffer
//   issued_cnt        saturating count of handshakes since start
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt
);

  fetch_state_t      r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_inst_pc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_fire;
  logic              w_load_ok;
  logic              w_halt;
  logic              w_cnt_max;
  logic [PC_W-1:0]   w_pc_inc;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_fire    = r_valid & inst_ready;
  assign w_load_ok = ~r_valid | inst_ready;
  assign w_halt    = (imem_inst == HALT_WORD);
  assign w_cnt_max = &r_cnt;
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_cnt     <= '0;
    end else begin
      // Counted in every state; a start below
      // overrides it with a fresh zero.
      if (w_fire && !w_cnt_max)
        r_cnt <= w_cnt_inc;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_pc    <= start_addr;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end

        RUN: begin
          if (redirect) begin
            // Buffered word is dropped even
            // if it fires this cycle.
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
          end else if (w_load_ok) begin
            if (w_halt) begin
              // load_ok implies the buffer is
              // empty or draining now.
              r_state <= HALT;
              r_valid <= 1'b0;
            end else begin
              r_inst    <= imem_inst;
              r_inst_pc <= r_pc;
              r_valid   <= 1'b1;
              r_pc      <= w_pc_inc;
            end
          end
        end

        HALT: begin
          if (redirect) begin
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
            r_state <= RUN;
          end else if (start) begin
            r_pc    <= start_addr;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_state <= RUN;
          end else if (w_fire) begin
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_pc    = r_pc;
  assign inst_valid = r_valid;
  assign inst_out   = r_inst;
  assign inst_pc    = r_inst_pc;
  assign issued_cnt = r_cnt;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == HALT) & ~r_valid;

endmodule
